rng_rd_buf: RTL and testbench

Consumer-side buffer for the conditioned random-number stream produced by the entropy combiner (`rand_num`/`rand_num_valid`). It samples valid 64-bit words, applies a repetition-count health test, stores passing words in a small FIFO, and serves them to a core-side requester over a req/ack handshake. It sits between the RNG conditioner and the CSR/peripheral read path. Its sticky error flag stops bad entropy from reaching software.

---
 rtl/rng_pkg.sv | 14 +
 rtl/rng_sync_fifo.sv | 69 ++++++
 rtl/rng_rd_buf.sv | 149 ++++++++++++++
 tb/tb_rng_rd_buf.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared types and constants for the RNG read buffer
package rng_pkg;

    localparam int RNG_W             = 64;
    localparam int RNG_DEF_DEPTH     = 4;
    localparam int RNG_DEF_REP_LIMIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rng_sync_fifo.sv
// rtl/rng_sync_fifo.sv - single-clock FIFO with synchronous flush
module rng_sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO refuses a push even when a pop lands on the same edge.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush overrides any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rng_rd_buf.sv
// rtl/rng_rd_buf.sv - health-tested random word buffer with req/ack read port
module rng_rd_buf
    import rng_pkg::*;
#(
    parameter int DEPTH     = RNG_DEF_DEPTH,
    parameter int REP_LIMIT = RNG_DEF_REP_LIMIT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [RNG_W-1:0]             rand_num_i,
    input  logic                         rand_num_valid_i,
    input  logic                         req_i,
    output logic                         ack_o,
    output logic [RNG_W-1:0]             data_o,
    output logic                         err_o,
    input  logic                         clr_err_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int RW = $clog2(REP_LIMIT);

    rd_state_e        state_q;
    rd_state_e        state_d;
    logic [RNG_W-1:0] last_word_q;
    logic [RW-1:0]    rep_cnt_q;
    logic             err_q;
    logic [RNG_W-1:0] data_q;

    logic             is_rep;
    logic             hit;
    logic             fresh;
    logic             err_set;
    logic             fifo_push;
    logic             fifo_pop;
    logic             serve;
    logic [RNG_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_full;

    // Health test classification of the incoming word.
    assign is_rep  = (rand_num_i == last_word_q);
    assign hit     = rand_num_valid_i && is_rep;
    assign fresh   = rand_num_valid_i && !is_rep;
    assign err_set = hit && (rep_cnt_q == RW'(REP_LIMIT - 2));

    // Only fresh words reach the FIFO, and nothing enters while in error.
    assign fifo_push = fresh && !err_q;

    // A request is served once data exists or the error path forces a zero reply.
    assign serve    = ((state_q == IDLE && req_i) || state_q == WAIT)
                      && (!fifo_empty || err_q);
    assign fifo_pop = serve && !err_q;

    rng_sync_fifo #(
        .W     (RNG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (rand_num_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .flush     (err_set),
        .count     (count_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign empty_o = fifo_empty;
    assign full_o  = fifo_full;
    assign err_o   = err_q;
    assign data_o  = data_q;
    assign ack_o   = (state_q == ACK);

    // Track the previous distinct word and how many times it has repeated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word_q <= '0;
            rep_cnt_q   <= '0;
        end else begin
            if (fresh) begin
                last_word_q <= rand_num_i;
            end
            if (clr_err_i || fresh) begin
                rep_cnt_q <= '0;
            end else if (hit && rep_cnt_q != RW'(REP_LIMIT - 1)) begin
                rep_cnt_q <= rep_cnt_q + RW'(1);
            end
        end
    end

    // Sticky error: a trip in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (clr_err_i) begin
            err_q <= 1'b0;
        end
    end

    // Capture the returned word on the edge that enters ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (serve) begin
            data_q <= err_q ? '0 : fifo_head;
        end
    end

    // Read handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read handshake next state; ACK lasts one cycle and ignores req_i.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (serve) begin
                    state_d = ACK;
                end else if (req_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (serve) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rng_rd_buf.sv
// tb/tb_rng_rd_buf.sv - self-checking bench for rng_rd_buf
module tb_rng_rd_buf;

    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 3;

    localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] WX = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] WD = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam logic [63:0] W5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] W7 = 64'h7777_7777_7777_7777;
    localparam logic [63:0] W8 = 64'h8888_8888_8888_8888;
    localparam logic [63:0] W9 = 64'h9999_9999_9999_9999;
    localparam logic [63:0] WA = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] B1 = 64'hB1B1_B1B1_B1B1_B1B1;
    localparam logic [63:0] B2 = 64'hB2B2_B2B2_B2B2_B2B2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rand_num;
    logic        rand_num_valid;
    logic        req;
    logic        ack;
    logic [63:0] data;
    logic        err;
    logic        clr_err;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rng_rd_buf #(
        .DEPTH     (DEPTH),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rand_num_i       (rand_num),
        .rand_num_valid_i (rand_num_valid),
        .req_i            (req),
        .ack_o            (ack),
        .data_o           (data),
        .err_o            (err),
        .clr_err_i        (clr_err),
        .count_o          (count),
        .empty_o          (empty),
        .full_o           (full)
    );

    typedef struct {
        logic        v;
        logic [63:0] w;
        logic        rq;
        logic        clr;
        logic        ack;
        logic [63:0] data;
        logic        err;
        logic [2:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [63:0] w, input logic rq,
                                input logic clr, input logic a, input logic [63:0] d,
                                input logic e, input logic [2:0] c);
        vec_t r;
        r.v = v; r.w = w; r.rq = rq; r.clr = clr;
        r.ack = a; r.data = d; r.err = e; r.cnt = c;
        return r;
    endfunction

    task automatic idle_inputs();
        rand_num_valid = 1'b0;
        rand_num       = '0;
        req            = 1'b0;
        clr_err        = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            rand_num_valid = tbl[i].v;
            rand_num       = tbl[i].w;
            req            = tbl[i].rq;
            clr_err        = tbl[i].clr;
            step();
            check($sformatf("tbl%0d ack", i), 64'(ack), 64'(tbl[i].ack));
            check($sformatf("tbl%0d data", i), data, tbl[i].data);
            check($sformatf("tbl%0d err", i), 64'(err), 64'(tbl[i].err));
            check($sformatf("tbl%0d count", i), 64'(count), 64'(tbl[i].cnt));
            check($sformatf("tbl%0d empty", i), 64'(empty), 64'(tbl[i].cnt == 3'd0));
            check($sformatf("tbl%0d full", i), 64'(full), 64'(tbl[i].cnt == 3'(DEPTH)));
        end
        idle_inputs();
    endtask

    task automatic run_random(input int cycles);
        logic [63:0] pool [4];
        logic [63:0] q[$];
        logic [63:0] mlast;
        logic [63:0] mdata;
        int          mrep;
        bit          merr;
        int          mmode;
        logic        v;
        logic [63:0] w;
        logic        clr;
        bit          can, srv, full_pre, set, pushok;

        pool[0] = 64'h0;
        pool[1] = 64'hC0FF_EE00_1234_0001;
        pool[2] = 64'hFACE_B00C_0000_0002;
        pool[3] = 64'h0123_4567_89AB_CDEF;
        mlast = '0; mdata = '0; mrep = 0; merr = 0; mmode = 0;
        req = 1'b0;

        for (int c = 0; c < cycles; c++) begin
            v   = ($urandom_range(0, 2) != 0);
            w   = pool[$urandom_range(0, 3)];
            clr = ($urandom_range(0, 11) == 0);
            rand_num_valid = v;
            rand_num       = w;
            clr_err        = clr;

            can      = (q.size() != 0) || merr;
            srv      = ((mmode == 0 && req) || mmode == 1) && can;
            full_pre = (q.size() == DEPTH);
            set      = 0;
            pushok   = 0;
            if (v) begin
                if (w == mlast) begin
                    set = (mrep == REP_LIMIT - 2);
                    if (mrep < REP_LIMIT - 1) mrep++;
                end else begin
                    pushok = !full_pre && !merr;
                    mrep   = 0;
                    mlast  = w;
                end
            end
            if (clr) mrep = 0;
            if (srv) begin
                if (merr) mdata = '0;
                else      mdata = q.pop_front();
            end
            if (pushok) q.push_back(w);
            if (set) q.delete();
            merr = set ? 1'b1 : (clr ? 1'b0 : merr);
            if (mmode == 2)              mmode = 0;
            else if (srv)                mmode = 2;
            else if (mmode == 0 && req)  mmode = 1;

            step();
            check($sformatf("rnd%0d ack", c), 64'(ack), 64'(mmode == 2));
            check($sformatf("rnd%0d data", c), data, mdata);
            check($sformatf("rnd%0d err", c), 64'(err), 64'(merr));
            check($sformatf("rnd%0d count", c), 64'(count), 64'(q.size()));
            check($sformatf("rnd%0d empty", c), 64'(empty), 64'(q.size() == 0));
            check($sformatf("rnd%0d full", c), 64'(full), 64'(q.size() == DEPTH));

            if (ack)       req = 1'b0;
            else if (!req) req = ($urandom_range(0, 5) == 0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        check("rst ack", 64'(ack), 64'd0);
        check("rst data", data, 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst count", 64'(count), 64'd0);
        check("rst empty", 64'(empty), 64'd1);
        check("rst full", 64'(full), 64'd0);
        rst_n = 1'b1;

        //            v  word rq clr ack data err cnt
        tbl.push_back(mk(1, W1, 0, 0, 0, 0,  0, 1));
        tbl.push_back(mk(1, W2, 0, 0, 0, 0,  0, 2));
        tbl.push_back(mk(1, W3, 0, 0, 0, 0,  0, 3));
        tbl.push_back(mk(0, 0,  1, 0, 1, W1, 0, 2));
        tbl.push_back(mk(0, 0,  0, 0, 0, W1, 0, 2));
        tbl.push_back(mk(0, 0,  1, 0, 1, W2, 0, 1));
        tbl.push_back(mk(0, 0,  0, 0, 0, W2, 0, 1));
        tbl.push_back(mk(0, 0,  1, 0, 1, W3, 0, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, W3, 0, 0));
        tbl.push_back(mk(1, WX, 0, 0, 0, W3, 0, 1));
        tbl.push_back(mk(1, WD, 0, 0, 0, W3, 0, 2));
        tbl.push_back(mk(1, WD, 0, 0, 0, W3, 0, 2));
        tbl.push_back(mk(1, WD, 0, 0, 0, W3, 1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 1, 0,  1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 0,  0, 1, 0, 0,  0, 0));
        tbl.push_back(mk(1, W5, 0, 0, 0, 0,  0, 1));
        tbl.push_back(mk(1, W7, 0, 0, 0, 0,  0, 2));
        tbl.push_back(mk(1, W7, 0, 0, 0, 0,  0, 2));
        tbl.push_back(mk(1, W8, 0, 0, 0, 0,  0, 3));
        tbl.push_back(mk(1, W7, 0, 0, 0, 0,  0, 4));
        tbl.push_back(mk(1, W7, 0, 0, 0, 0,  0, 4));
        tbl.push_back(mk(1, W9, 0, 0, 0, 0,  0, 4));
        tbl.push_back(mk(0, 0,  1, 0, 1, W5, 0, 3));
        tbl.push_back(mk(0, 0,  0, 0, 0, W5, 0, 3));
        run_table();

        begin
            logic [63:0] rest [3];
            rest[0] = W7; rest[1] = W8; rest[2] = W7;
            for (int k = 0; k < 3; k++) begin
                req = 1'b1;
                step();
                check($sformatf("drain%0d ack", k), 64'(ack), 64'd1);
                check($sformatf("drain%0d data", k), data, rest[k]);
                req = 1'b0;
                step();
                check($sformatf("drain%0d ack low", k), 64'(ack), 64'd0);
            end
            check("drain empty", 64'(empty), 64'd1);
        end

        req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("wait%0d ack", k), 64'(ack), 64'd0);
        end
        rand_num_valid = 1'b1;
        rand_num       = WA;
        step();
        check("wait push count", 64'(count), 64'd1);
        check("wait push ack", 64'(ack), 64'd0);
        rand_num_valid = 1'b0;
        step();
        check("wait ack", 64'(ack), 64'd1);
        check("wait data", data, WA);
        check("wait count", 64'(count), 64'd0);
        req = 1'b0;
        step();
        check("wait ack low", 64'(ack), 64'd0);

        rand_num_valid = 1'b1;
        rand_num       = B1;
        step();
        rand_num       = B2;
        step();
        rand_num_valid = 1'b0;
        req            = 1'b1;
        step();
        check("rstack ack", 64'(ack), 64'd1);
        check("rstack data", data, B1);
        check("rstack count", 64'(count), 64'd1);
        req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async ack", 64'(ack), 64'd0);
        check("async count", 64'(count), 64'd0);
        check("async err", 64'(err), 64'd0);
        check("async data", data, 64'd0);
        step();
        rst_n = 1'b1;
        req   = 1'b1;
        step();
        check("post rst ack", 64'(ack), 64'd0);
        step();
        check("post rst ack2", 64'(ack), 64'd0);
        check("post rst count", 64'(count), 64'd0);

        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_random(600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
